// File: rtl/dot_product_sequencer.sv
// Dot-product sequencer for the compute phase.
// On start it reads A[i] and B[i] alternately from the shared operand memory
// through a single read port, then multiply-accumulates each pair. At the end
// it produces a one-cycle done pulse together with a saturated or truncated
// result and an overflow flag. Clearing mode_compute while busy aborts the run.
//
// Handshake: there is no valid/ready pair. start is sampled only in IDLE and
// only when mode_compute is high. mem_rd qualifies mem_addr, and mem_rdata is
// consumed exactly one cycle after each read. done qualifies result/overflow
// for one cycle; the two values are then held until the next done.
module dot_product_sequencer #(
  parameter int N_ELEM = 8,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int B_BASE = 8,
  parameter int ACC_W  = 19,
  parameter int SAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode_compute,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              overflow,
  output logic [1:0]        dbg_state
);

  localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_ELEM - 1);
  localparam logic [ACC_W-1:0]  MAX_VAL  = (ACC_W'(1) << DATA_W) - ACC_W'(1);
  localparam logic [ADDR_W-1:0] B_ADDR   = ADDR_W'(B_BASE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_A = 2'd1,
    RD_B = 2'd2,
    MAC  = 2'd3
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [ACC_W-1:0]   acc_q;
  logic [DATA_W-1:0]  a_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic               mem_rd_q;
  logic               busy_q;
  logic               done_q;
  logic [DATA_W-1:0]  result_q;
  logic               overflow_q;

  logic [ACC_W-1:0]   sum_d;
  logic [IDX_W-1:0]   idx_d;
  logic               ovf_d;
  logic [DATA_W-1:0]  result_d;

  // MAC datapath: the accumulator is wide enough that the sum never wraps.
  always_comb begin
    sum_d    = acc_q + ACC_W'(a_q) * ACC_W'(mem_rdata);
    idx_d    = idx_q + IDX_W'(1);
    ovf_d    = (sum_d > MAX_VAL);
    result_d = sum_d[DATA_W-1:0];
    if (SAT != 0 && ovf_d) begin
      result_d = {DATA_W{1'b1}};
    end
  end

  // Sequencer FSM. The memory-side and busy outputs are registered and are
  // loaded with the values that belong to the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      acc_q      <= '0;
      a_q        <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE && !mode_compute) begin
        // Abort: drop back to IDLE and leave result/overflow untouched.
        state_q    <= IDLE;
        mem_addr_q <= '0;
        mem_rd_q   <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start && mode_compute) begin
              acc_q      <= '0;
              idx_q      <= '0;
              state_q    <= RD_A;
              mem_addr_q <= '0;
              mem_rd_q   <= 1'b1;
              busy_q     <= 1'b1;
            end
          end
          RD_A: begin
            state_q    <= RD_B;
            mem_addr_q <= B_ADDR + ADDR_W'(idx_q);
            mem_rd_q   <= 1'b1;
          end
          RD_B: begin
            // mem_rdata carries A[idx] requested in RD_A.
            a_q        <= mem_rdata;
            state_q    <= MAC;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
          end
          MAC: begin
            // mem_rdata carries B[idx] requested in RD_B.
            if (idx_q != LAST_IDX) begin
              acc_q      <= sum_d;
              idx_q      <= idx_d;
              state_q    <= RD_A;
              mem_addr_q <= ADDR_W'(idx_d);
              mem_rd_q   <= 1'b1;
            end else begin
              state_q    <= IDLE;
              mem_addr_q <= '0;
              mem_rd_q   <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              overflow_q <= ovf_d;
              result_q   <= result_d;
            end
          end
          default: begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            busy_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Bench for dot_product_sequencer: a saturating and a truncating instance share
// one operand memory model. Expected results are pushed at stimulus time and
// popped by per-instance monitors on each done pulse.
module tb_dot_product_sequencer;

  localparam int LAT = 25;  // from the drive cycle of start to the done cycle
  localparam int EW  = 25;  // {due_cycle[15:0], overflow, result[7:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic mode_compute = 1'b0;
  logic start_s = 1'b0;
  logic start_t = 1'b0;

  logic [3:0] s_mem_addr, t_mem_addr;
  logic       s_mem_rd, t_mem_rd;
  logic [7:0] s_rdata, t_rdata;
  logic       s_busy, t_busy, s_done, t_done, s_overflow, t_overflow;
  logic [7:0] s_result, t_result;
  logic [1:0] s_state, t_state;

  dot_product_sequencer #(.SAT(1)) u_sat (
    .clk(clk), .rst(rst), .start(start_s), .mode_compute(mode_compute),
    .mem_addr(s_mem_addr), .mem_rd(s_mem_rd), .mem_rdata(s_rdata),
    .busy(s_busy), .done(s_done), .result(s_result), .overflow(s_overflow),
    .dbg_state(s_state)
  );

  dot_product_sequencer #(.SAT(0)) u_trn (
    .clk(clk), .rst(rst), .start(start_t), .mode_compute(mode_compute),
    .mem_addr(t_mem_addr), .mem_rd(t_mem_rd), .mem_rdata(t_rdata),
    .busy(t_busy), .done(t_done), .result(t_result), .overflow(t_overflow),
    .dbg_state(t_state)
  );

  // Operand memory: one read port per instance, 1-cycle latency.
  logic [7:0] mem [16];
  initial begin
    s_rdata = '0;
    t_rdata = '0;
  end
  always @(posedge clk) begin
    if (s_mem_rd) s_rdata <= mem[s_mem_addr];
    if (t_mem_rd) t_rdata <= mem[t_mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_s[$];
  logic [EW-1:0] exp_t[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mon_s
    logic [EW-1:0] e;
    if (!rst && s_done) begin
      if (exp_s.size() == 0) begin
        check("sat_unexpected_done", 1, 0);
      end else begin
        e = exp_s.pop_front();
        check("sat_result", s_result, e[7:0]);
        check("sat_overflow", s_overflow, e[8]);
        check("sat_done_cycle", cyc, e[24:9]);
      end
    end
  end

  always @(negedge clk) begin : mon_t
    logic [EW-1:0] e;
    if (!rst && t_done) begin
      if (exp_t.size() == 0) begin
        check("trn_unexpected_done", 1, 0);
      end else begin
        e = exp_t.pop_front();
        check("trn_result", t_result, e[7:0]);
        check("trn_overflow", t_overflow, e[8]);
        check("trn_done_cycle", cyc, e[24:9]);
      end
    end
  end

  // Address trace monitor for the saturating instance.
  logic trace_en = 1'b0;
  int   trace_base = 0;
  int   n_reads = 0;
  always @(negedge clk) begin
    if (trace_en && s_mem_rd) begin
      check("trace_addr", s_mem_addr, (n_reads % 2 == 0) ? n_reads / 2 : 8 + n_reads / 2);
      check("trace_cycle", cyc, trace_base + 1 + 3 * (n_reads / 2) + (n_reads % 2));
      n_reads++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_ab(input int mode);
    for (int i = 0; i < 8; i++) begin
      case (mode)
        0: begin mem[i] = 8'(i + 1); mem[8 + i] = 8'd1;       end  // 1..8 . 1s = 36
        1: begin mem[i] = 8'd255;    mem[8 + i] = 8'd255;     end  // 520200
        2: begin mem[i] = 8'd0;      mem[8 + i] = 8'd0;       end
        default: begin mem[i] = 8'(i + 1); mem[8 + i] = 8'(8 - i); end  // 120
      endcase
    end
    if (mode == 2) begin
      mem[0] = 8'd16;
      mem[8] = 8'd16;  // 256
    end
  endtask

  task automatic issue(input bit trn, input int res, input bit ovf);
    @(posedge clk); #1;
    if (trn) begin
      start_t = 1'b1;
      exp_t.push_back({16'(cyc + LAT), ovf, 8'(res)});
    end else begin
      start_s = 1'b1;
      exp_s.push_back({16'(cyc + LAT), ovf, 8'(res)});
    end
    @(posedge clk); #1;
    start_s = 1'b0;
    start_t = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60 && (exp_s.size() != 0 || exp_t.size() != 0); i++) @(posedge clk);
    #1;
    check(name, exp_s.size() + exp_t.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, s_busy, 0);
    check({tag, "_done"}, s_done, 0);
    check({tag, "_result"}, s_result, 0);
    check({tag, "_overflow"}, s_overflow, 0);
    check({tag, "_mem_rd"}, s_mem_rd, 0);
    check({tag, "_mem_addr"}, s_mem_addr, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    load_ab(0);
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // start without mode_compute is ignored
    @(posedge clk); #1; start_s = 1'b1;
    @(posedge clk); #1; start_s = 1'b0;
    check("start_no_mode_busy", s_busy, 0);
    mode_compute = 1'b1;

    // T1/T2: ramp . ones = 36, with address trace
    @(posedge clk); #1;
    trace_base = cyc;
    n_reads = 0;
    trace_en = 1'b1;
    start_s = 1'b1;
    exp_s.push_back({16'(cyc + LAT), 1'b0, 8'd36});
    @(posedge clk); #1;
    start_s = 1'b0;
    check("t1_busy_after_start", s_busy, 1);
    wait_drain("t1_drain");
    trace_en = 1'b0;
    check("t2_read_count", n_reads, 16);
    check("t1_busy_after_done", s_busy, 0);

    // T3: saturation and truncation
    load_ab(1);
    issue(0, 255, 1);
    wait_drain("t3_sat_drain");
    load_ab(2);
    issue(1, 0, 1);
    wait_drain("t3_trn_drain");
    load_ab(0);
    issue(1, 36, 0);
    wait_drain("t3_trn_small_drain");

    // T4: abort mid-run keeps previous result
    issue(0, 36, 0);
    wait_drain("t4_pre_drain");
    @(posedge clk); #1; start_s = 1'b1;
    @(posedge clk); #1; start_s = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    mode_compute = 1'b0;
    @(posedge clk); #1;
    check("t4_abort_busy", s_busy, 0);
    check("t4_abort_mem_rd", s_mem_rd, 0);
    repeat (30) @(posedge clk);
    #1;
    check("t4_result_held", s_result, 36);
    check("t4_overflow_held", s_overflow, 0);
    mode_compute = 1'b1;
    issue(0, 36, 0);
    wait_drain("t4_rerun_drain");

    // T5: start while busy ignored; start in done cycle accepted
    load_ab(3);
    @(posedge clk); #1;
    c = cyc;
    start_s = 1'b1;
    exp_s.push_back({16'(c + LAT), 1'b0, 8'd120});
    @(posedge clk); #1; start_s = 1'b0;
    repeat (c + 5 - cyc) @(posedge clk);
    #1; start_s = 1'b1;
    @(posedge clk); #1; start_s = 1'b0;
    repeat (c + 12 - cyc) @(posedge clk);
    #1; start_s = 1'b1;
    @(posedge clk); #1; start_s = 1'b0;
    repeat (c + LAT - cyc) @(posedge clk);
    #1;
    check("t5_done_cycle_level", s_done, 1);
    start_s = 1'b1;
    exp_s.push_back({16'(cyc + LAT), 1'b0, 8'd120});
    @(posedge clk); #1; start_s = 1'b0;
    check("t5_restart_busy", s_busy, 1);
    wait_drain("t5_drain");

    // T6: reset mid-run, then a clean run
    load_ab(0);
    @(posedge clk); #1; start_s = 1'b1;
    @(posedge clk); #1; start_s = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("t6_busy_before_rst", s_busy, 1);
    rst = 1'b1;
    #1;
    check_zero("t6_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    issue(0, 36, 0);
    wait_drain("t6_drain");

    repeat (5) @(posedge clk);
    #1;
    check("final_queue_empty", exp_s.size() + exp_t.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
